// File: rtl/bcd_scan_counter.sv
// ---------------------------------------------------------------------------
// bcd_scan_counter
//
// Multi-digit BCD up/down counter with parallel load and wrap carry, plus a
// time-multiplexed seven-segment scan driver that shares one segment bus
// across DIGITS digits with per-digit active-low anode selects.
//
// Parameters:
//   DIGITS    number of BCD digits (1..8)
//   SCAN_DIV  clk cycles each digit is shown before the scan advances (>= 2)
//
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-low reset
//   en     count enable, one step per cycle while high
//   load   synchronous parallel load of din (wins over en)
//   up_dn  1 = count up, 0 = count down
//   din    load value, nibble 0 is the least significant digit
//   count  current BCD value (registered)
//   carry  one-cycle pulse after a wrap in either direction (registered)
//   seg    active-low segments {g,f,e,d,c,b,a} (registered)
//   an     active-low one-hot digit select (registered)
//
// Optional build macro:
//   BCD_SCAN_LEADING_ZERO_BLANK_EN  blank digits above the most significant
//                                   nonzero digit; digit 0 is never blanked.
// ---------------------------------------------------------------------------
module bcd_scan_counter #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 1000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                load,
   input  logic                up_dn,
   input  logic [4*DIGITS-1:0] din,
   output logic [4*DIGITS-1:0] count,
   output logic                carry,
   output logic [6:0]          seg,
   output logic [DIGITS-1:0]   an
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;

   logic [4*DIGITS-1:0] count_next;
   logic                carry_next;
   logic                ripple;

   logic [DIV_W-1:0]    div_cnt;
   logic [DIV_W-1:0]    div_next;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    idx_next;

   logic [3:0]          sel_digit;
   logic [DIGITS-1:0]   blank;
   logic [6:0]          seg_next;
   logic [DIGITS-1:0]   an_next;

   // Active-low glyph table, bit order {g,f,e,d,c,b,a}. Non-BCD codes can
   // never reach here, they decode to blank only for completeness.
   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0:    g = 7'b1000000;
         4'd1:    g = 7'b1111001;
         4'd2:    g = 7'b0100100;
         4'd3:    g = 7'b0110000;
         4'd4:    g = 7'b0011001;
         4'd5:    g = 7'b0010010;
         4'd6:    g = 7'b0000010;
         4'd7:    g = 7'b1111000;
         4'd8:    g = 7'b0000000;
         4'd9:    g = 7'b0011000;
         default: g = SEG_BLANK;
      endcase
      return g;
   endfunction

   // Next count. Load clamps each nibble to 9 so count can never hold a
   // non-BCD digit. When counting, 'ripple' carries the increment/borrow
   // upward through the digits in the same cycle; if it survives past the
   // top digit the whole counter wrapped and carry fires next cycle.
   always_comb begin
      count_next = count;
      carry_next = 1'b0;
      ripple     = 1'b1;
      if (load) begin
         for (int i = 0; i < DIGITS; i++) begin
            count_next[4*i +: 4] = (din[4*i +: 4] > 4'd9) ? 4'd9 : din[4*i +: 4];
         end
      end else if (en) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (ripple) begin
               if (up_dn) begin
                  if (count[4*i +: 4] == 4'd9) begin
                     count_next[4*i +: 4] = 4'd0;
                  end else begin
                     count_next[4*i +: 4] = count[4*i +: 4] + 4'd1;
                     ripple = 1'b0;
                  end
               end else begin
                  if (count[4*i +: 4] == 4'd0) begin
                     count_next[4*i +: 4] = 4'd9;
                  end else begin
                     count_next[4*i +: 4] = count[4*i +: 4] - 4'd1;
                     ripple = 1'b0;
                  end
               end
            end
         end
         carry_next = ripple;
      end
   end

   // Scan divider and digit index. The divider free-runs regardless of
   // en/load; the index advances once per divider wrap.
   always_comb begin
      div_next = div_cnt + 1'b1;
      idx_next = idx;
      if (div_cnt == DIV_LAST) begin
         div_next = '0;
         idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
   end

   // Leading-zero detection: scanning from the top digit down, a digit is
   // blank while every digit at or above it is zero. Digit 0 is excluded so
   // a value of zero still shows a single "0".
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
   logic upper_zero;

   always_comb begin
      blank      = '0;
      upper_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         upper_zero = upper_zero && (count[4*i +: 4] == 4'd0);
         blank[i]   = upper_zero;
      end
   end
`else
   assign blank = '0;
`endif

   // Segment and anode decode use the next-state index so that the
   // registered seg and an always refer to the same digit. The digit value
   // comes from the current count register, which is why seg trails a count
   // change by one cycle.
   assign sel_digit = count[4*idx_next +: 4];
   assign seg_next  = blank[idx_next] ? SEG_BLANK : glyph(sel_digit);
   assign an_next   = ~(DIGITS'(1) << idx_next);

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count   <= '0;
         carry   <= 1'b0;
         div_cnt <= '0;
         idx     <= '0;
         an      <= ~DIGITS'(1);
         seg     <= SEG_ZERO;
      end else begin
         count   <= count_next;
         carry   <= carry_next;
         div_cnt <= div_next;
         idx     <= idx_next;
         an      <= an_next;
         seg     <= seg_next;
      end
   end

endmodule
